// File: rtl/cacheline_adaptor.sv
// Converts one cacheline read/write from the cache side into a fixed-length
// burst of narrower beats on the physical memory bus, with a one-cycle response.
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64,
  parameter int n_beats  = 4,
  localparam int line_w  = 8 * (1 << s_offset),
  localparam int cnt_w   = (n_beats > 1) ? $clog2(n_beats) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [line_w-1:0] line_i,
  output logic [line_w-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_beat-1:0] burst_i,
  output logic [s_beat-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);

  state_t            r_state;
  logic [cnt_w-1:0]  r_count;
  logic [line_w-1:0] r_line;   // read buffer, only ever filled by READ bursts
  logic [line_w-1:0] r_wline;  // write line latched at request time
  logic [31:0]       r_addr;
  logic              r_read;
  logic              r_write;
  logic              r_resp;
  logic [s_beat-1:0] w_burst;

  assign w_burst   = r_wline[r_count*s_beat +: s_beat];
  assign burst_o   = w_burst;
  assign line_o    = r_line;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_line  <= '0;
      r_wline <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp  <= 1'b0;
          r_count <= '0;
          // Write wins when both requests are raised together
          if (write_i) begin
            r_wline <= line_i;
            r_addr  <= {address_i[31:s_offset], {s_offset{1'b0}}};
            r_write <= 1'b1;
            r_state <= WRITE;
          end else if (read_i) begin
            r_addr  <= {address_i[31:s_offset], {s_offset{1'b0}}};
            r_read  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            r_line[r_count*s_beat +: s_beat] <= burst_i;
            r_count <= r_count + 1'b1;
            if (r_count == last_beat) begin
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_count <= r_count + 1'b1;
            if (r_count == last_beat) begin
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized bench for cacheline_adaptor: a line-level model
// predicts line_o, the burst beat order and the request/response timing.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  // Reference model: the line the cache should see, and pending write beats
  logic [255:0] exp_line;
  logic [63:0]  exp_q[$];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " read_o"}, read_o, 1'b0);
    chk({tag, " write_o"}, write_o, 1'b0);
    chk({tag, " resp_o"}, resp_o, 1'b0);
  endtask

  // One cache transaction. Called at #1 after an edge with the DUT in IDLE.
  // pat gives resp_i per cycle (LSB first) when use_pat, else random stalls.
  // abort_after>0 pulses rst once that many read beats have been accepted.
  task automatic xfer(input bit is_wr, input bit both, input logic [31:0] addr,
                      input logic [255:0] data, input logic [15:0] pat,
                      input bit use_pat, input int abort_after);
    int n;
    int cyc;
    logic [31:0] exp_addr;
    exp_addr  = addr & 32'hFFFF_FFE0;
    write_i   = is_wr;
    read_i    = !is_wr || both;
    address_i = addr;
    line_i    = is_wr ? data : {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
    resp_i    = 1'b0;
    if (is_wr)
      for (int k = 0; k < 4; k++) exp_q.push_back(data[64*k +: 64]);
    tick();
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < 64) begin
      chk("busy read_o", read_o, !is_wr);
      chk("busy write_o", write_o, is_wr);
      chk("busy resp_o", resp_o, 1'b0);
      chk("address_o", address_o, exp_addr);
      chk("busy line_o", line_o, exp_line);
      if (is_wr) chk("burst_o", burst_o, exp_q[0]);
      resp_i  = use_pat ? ((cyc < 16) ? pat[cyc] : 1'b1) : ($urandom_range(0, 3) != 0);
      burst_i = {$urandom, $urandom};
      if (resp_i) begin
        if (is_wr) void'(exp_q.pop_front());
        else begin
          burst_i = data[64*n +: 64];
          exp_line[64*n +: 64] = data[64*n +: 64];
        end
        n++;
      end
      tick();
      cyc++;
      if (!is_wr && abort_after != 0 && n == abort_after) begin
        rst    = 1'b1;
        read_i = 1'b0;
        resp_i = 1'b0;
        tick();
        exp_line = '0;
        chk_idle("abort");
        chk("abort line_o", line_o, exp_line);
        chk("abort address_o", address_o, 32'h0);
        rst = 1'b0;
        tick();
        chk_idle("post-abort");
        return;
      end
    end
    chk("beats accepted", n, 4);
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    chk("done resp_o", resp_o, 1'b1);
    chk("done read_o", read_o, 1'b0);
    chk("done write_o", write_o, 1'b0);
    chk("done line_o", line_o, exp_line);
    // Request still held during the response cycle; it must be ignored
    tick();
    chk_idle("after done");
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
    chk_idle("idle");
    chk("idle line_o", line_o, exp_line);
  endtask

  initial begin
    logic [255:0] d;
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    exp_line  = '0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset line_o", line_o, 256'h0);
    chk("reset burst_o", burst_o, 64'h0);
    chk("reset address_o", address_o, 32'h0);
    rst = 1'b0;
    tick();
    chk_idle("post-reset");

    // Zero-stall read with fixed beats
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    xfer(1'b0, 1'b0, 32'h0000_1234, d, 16'hFFFF, 1'b1, 0);
    chk("read line constant", line_o, d);

    // Zero-stall write
    d = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
         64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF};
    xfer(1'b1, 1'b0, 32'h0000_0FFF, d, 16'hFFFF, 1'b1, 0);
    chk("write leaves line_o", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Stalled read: resp_i = 1,0,0,1,1,0,1
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b0, 1'b0, 32'hDEAD_BEEF, d, 16'h0059, 1'b1, 0);

    // Both requests: write wins, line_o untouched
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b1, 1'b1, 32'h0000_2040, d, 16'hFFFF, 1'b1, 0);

    // Reset after beat 2 of a read, then a fresh read
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b0, 1'b0, 32'h0000_3000, d, 16'hFFFF, 1'b1, 2);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b0, 1'b0, 32'h0000_301F, d, 16'hFFFF, 1'b1, 0);

    // Back-to-back reads
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b0, 1'b0, 32'h0000_4000, d, 16'hFFFF, 1'b1, 0);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b0, 1'b0, 32'h0000_4020, d, 16'hFFFF, 1'b1, 0);

    // Randomized transactions with random stalls
    for (int t = 0; t < 40; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, d, 16'h0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the instruction cache's physical-memory port, and of the data cache's port via the memory arbiter.
- Converts one 256-bit cacheline read or write into a 4-beat, 64-bit burst transaction on the physical memory bus.
- Provides the pmem_rdata/pmem_resp handshake the caches expect: one request in, one single-cycle response out.

Parameters:
- s_offset, 5, byte-offset bits in a line; line = 2**s_offset bytes = 256 bits.
- s_beat, 64, burst data width in bits.
- n_beats, 4, beats per line (= 256/s_beat).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- line_i  input  256  write line from cache
- line_o  output  256  assembled read line to cache
- address_i  input  32  cache request address
- read_i  input  1  cache read request; held until resp_o
- write_i  input  1  cache write request; held until resp_o
- resp_o  output  1  transaction complete; one-cycle pulse
- burst_i  input  64  memory read beat
- burst_o  output  64  memory write beat
- address_o  output  32  line-aligned burst address
- read_o  output  1  memory burst read
- write_o  output  1  memory burst write
- resp_i  input  1  memory beat accepted or valid

Behaviour:
- Clocking: one clock, clk; reset is synchronous, active-high, on rst.
- Reset values: state=IDLE, beat count=0, line buffer=0, address register=0. Outputs: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
- States: IDLE, READ, WRITE, DONE.
- Beat ordering: beat k occupies line bits [64k+63:64k], k=0..3, beat 0 first.

IDLE:
- write_i=1: latch line_i, latch address_i with bits[4:0] zeroed, count=0, go to WRITE.
- Else read_i=1: latch address_i the same way, go to READ.
- Write takes priority if both requests are high.
- resp_i is ignored.

READ:
- read_o=1; address_o = latched address.
- Each cycle resp_i=1: buffer[count] <= burst_i, count++.
- resp_i=0 mid-burst is a stall: hold count, keep read_o high.
- On the 4th accepted beat: go to DONE. read_o is still 1 in that cycle and 0 from the next.

WRITE:
- write_o=1; burst_o = latched line[64*count +: 64].
- Each cycle resp_i=1: count++. Stalls are handled as in READ.
- On the 4th accepted beat: go to DONE.

DONE:
- resp_o=1 for exactly one cycle, then go to IDLE.
- read_i/write_i are ignored in this cycle; the cache drops its request on the cycle after resp_o.

line_o:
- Driven from the buffer and stable from the DONE cycle until the next READ's first accepted beat.
- Not updated by writes.

Latency (zero-stall memory):
- Read request sampled at cycle 0 → read_o high cycles 1-4 → resp_o at cycle 5.
- Write has the same timing.

Other rules:
- Requests arriving in READ/WRITE/DONE are not queued.
- rst mid-burst: return to IDLE next edge; read_o/write_o drop; count and buffer clear; no resp_o. The memory model must tolerate an abandoned burst.
- Count is 2 bits and wraps to 0 on the 4th beat; count is never ≥ 4.

Test Plan:
- Read, no stalls: addr 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → address_o=0x0000_1220, read_o high 4 cycles, resp_o at cycle 5, line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write, no stalls: line_i = 0x0123...ABCD pattern, addr 0x0000_0FFF → address_o=0x0000_0FE0, burst_o = line[63:0], [127:64], [191:128], [255:192] in order, write_o for 4 cycles, single resp_o.
- Stalled read: resp_i pattern 1,0,0,1,1,0,1 → exactly 4 beats captured in order, resp_o 1 cycle after the last beat, read_o held through stalls.
- Simultaneous read_i=write_i=1 in IDLE → WRITE burst performed, read_o never asserted, line_o unchanged.
- rst after beat 2 of a read → next cycle read_o=0, resp_o=0, line_o=0. A fresh read then completes correctly with 4 new beats.
- Back-to-back reads: request held through resp_o, dropped next cycle, new read 1 cycle later → second burst starts exactly one cycle after IDLE re-entry, no spurious third transaction.
